// File: rtl/spi_slave_receiver.sv
// SPI mode-0 slave: synchronizes SCLK/CS/MOSI into clk, shifts bytes in/out MSB first,
// and hands received bytes to a valid/ready consumer with sticky overrun/underrun flags.
module spi_slave_receiver #(
  parameter int         SYNC_STAGES    = 2,
  parameter logic [3:0] SPI_DATALENGTH = 4'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       underrun,
  output logic       frame_error
);

  typedef enum logic [1:0] {IDLE, ACTIVE, BYTE_DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  logic [3:0] bit_cnt_q, bit_cnt_d;
  // Only seven bits are stored; the eighth arrives on the completing sclk edge.
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_ready_q, tx_ready_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;
  logic       frame_error_q, frame_error_d;
  logic       miso_q, miso_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic last_bit, load_tx, byte_complete;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign last_bit  = (bit_cnt_q == SPI_DATALENGTH - 4'd1);

  always_comb begin
    state_d       = state_q;
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], CS};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d   = sclk_s;
    cs_prev_d     = cs_s;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    tx_ready_d    = 1'b0;
    overrun_d     = overrun_q;
    underrun_d    = underrun_q;
    frame_error_d = 1'b0;
    load_tx       = 1'b0;
    byte_complete = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // cs_rise is tested first so it wins over any sclk edge seen in the same cycle.
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 4'd0;
          load_tx   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d       = IDLE;
          frame_error_d = (bit_cnt_q != 4'd0);
          rx_shift_d    = 7'd0;
          bit_cnt_d     = 4'd0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[5:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (last_bit) begin
            state_d       = BYTE_DONE;
            byte_complete = 1'b1;
          end
        end else if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
      end
      BYTE_DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sclk_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = 4'd0;
          load_tx   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pending byte may only be replaced when the consumer takes it in this very cycle.
    if (byte_complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = {rx_shift_q, mosi_s};
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (load_tx) begin
      if (tx_valid) begin
        tx_shift_d = tx_data;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = 8'hFF;
        underrun_d = 1'b1;
      end
    end

    miso_d = (state_d != IDLE) && tx_shift_d[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '1;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      bit_cnt_q     <= 4'd0;
      rx_shift_q    <= 7'd0;
      tx_shift_q    <= 8'd0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      tx_ready_q    <= 1'b0;
      overrun_q     <= 1'b0;
      underrun_q    <= 1'b0;
      frame_error_q <= 1'b0;
      miso_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_ready_q    <= tx_ready_d;
      overrun_q     <= overrun_d;
      underrun_q    <= underrun_d;
      frame_error_q <= frame_error_d;
      miso_q        <= miso_d;
    end
  end

  assign MISO        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed bench for spi_slave_receiver: plays an SPI mode-0 master against the slave
// and checks received data, returned MISO bits, handshakes and status flags.
module tb_spi_slave_receiver;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0;
  logic       CS = 1'b1;
  logic       MOSI = 1'b1;
  logic       MISO;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       busy;
  logic       overrun;
  logic       underrun;
  logic       frame_error;

  int         vectors = 0;
  int         miscompares = 0;
  int         txReadyCount = 0;
  int         frameErrCount = 0;
  logic [7:0] handshakeQ[$];
  time        lastRiseTime = 0;
  time        riseDelta = 0;

  always #5 clk = ~clk;

  spi_slave_receiver dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun), .frame_error(frame_error)
  );

  // Observe pulses and rx transfers exactly as the edge that consumes them sees them.
  always @(posedge clk) begin
    if (tx_ready === 1'b1) txReadyCount++;
    if (frame_error === 1'b1) frameErrCount++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) handshakeQ.push_back(rx_data);
  end

  // Latency from the master's last SCLK rise to rx_valid going high.
  always @(posedge rx_valid) riseDelta = $time - lastRiseTime;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Shifts nbits of mosiByte out MSB first and collects what the slave returns on MISO.
  task automatic applyStimulus(input logic [7:0] mosiByte, input int nbits, input bit collideLast,
                               output logic [7:0] misoByte);
    misoByte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosiByte[7-i];
      waitClocks(HALF);
      misoByte = {misoByte[6:0], MISO};
      SCLK = 1'b1;
      lastRiseTime = $time;
      if (collideLast && i == nbits - 1) begin
        waitClocks(2);
        rx_ready = 1'b1;
        waitClocks(1);
        rx_ready = 1'b0;
        waitClocks(HALF - 3);
      end else begin
        waitClocks(HALF);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic resetDut();
    CS = 1'b1; SCLK = 1'b0; MOSI = 1'b1; rst = 1'b1;
    waitClocks(2);
    rst = 1'b0;
    waitClocks(2);
  endtask

  task automatic startFrame();
    CS = 1'b0;
    waitClocks(6);
  endtask

  task automatic endFrame();
    waitClocks(4);
    CS = 1'b1;
    waitClocks(6);
  endtask

  initial begin
    logic [7:0] misoByte;
    int         base;
    int         hsBase;
    logic [7:0] h0;
    logic [7:0] h1;

    waitClocks(1);
    resetDut();
    checkOutput("rst_miso", MISO, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_data", rx_data, 8'h00);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_tx_ready", tx_ready, 0);
    checkOutput("rst_frame_error", frame_error, 0);

    // Single byte: return A5, receive 3C.
    tx_data = 8'hA5; tx_valid = 1'b1;
    base = txReadyCount;
    hsBase = frameErrCount;
    startFrame();
    checkOutput("t1_busy", busy, 1);
    tx_valid = 1'b0;
    applyStimulus(8'h3C, 8, 1'b0, misoByte);
    checkOutput("t1_miso_byte", misoByte, 8'hA5);
    checkOutput("t1_rx_data", rx_data, 8'h3C);
    checkOutput("t1_rx_valid", rx_valid, 1);
    checkOutput("t1_valid_latency", 32'(riseDelta), 25);
    endFrame();
    checkOutput("t1_tx_ready_pulses", txReadyCount - base, 1);
    checkOutput("t1_busy_after", busy, 0);
    checkOutput("t1_no_frame_error", frameErrCount - hsBase, 0);

    // Back-to-back bytes with the consumer always ready.
    resetDut();
    rx_ready = 1'b1;
    hsBase = handshakeQ.size();
    startFrame();
    applyStimulus(8'h11, 8, 1'b0, misoByte);
    applyStimulus(8'h22, 8, 1'b0, misoByte);
    endFrame();
    rx_ready = 1'b0;
    h0 = (handshakeQ.size() > hsBase) ? handshakeQ[hsBase] : 8'h00;
    h1 = (handshakeQ.size() > hsBase + 1) ? handshakeQ[hsBase+1] : 8'h00;
    checkOutput("t2_handshakes", handshakeQ.size() - hsBase, 2);
    checkOutput("t2_first", h0, 8'h11);
    checkOutput("t2_second", h1, 8'h22);
    checkOutput("t2_overrun", overrun, 0);
    checkOutput("t2_rx_valid", rx_valid, 0);

    // Overrun: consumer never ready.
    resetDut();
    startFrame();
    applyStimulus(8'h55, 8, 1'b0, misoByte);
    checkOutput("t3_overrun_first", overrun, 0);
    applyStimulus(8'hAA, 8, 1'b0, misoByte);
    endFrame();
    checkOutput("t3_rx_data", rx_data, 8'h55);
    checkOutput("t3_rx_valid", rx_valid, 1);
    checkOutput("t3_overrun", overrun, 1);

    // Underrun and mid-byte abort after four bits.
    resetDut();
    tx_valid = 1'b0;
    base = frameErrCount;
    startFrame();
    applyStimulus(8'hB0, 4, 1'b0, misoByte);
    checkOutput("t4_miso_bits", misoByte, 8'h0F);
    checkOutput("t4_busy", busy, 1);
    CS = 1'b1;
    waitClocks(6);
    checkOutput("t4_frame_error_pulses", frameErrCount - base, 1);
    checkOutput("t4_frame_error_now", frame_error, 0);
    checkOutput("t4_underrun", underrun, 1);
    checkOutput("t4_rx_valid", rx_valid, 0);
    checkOutput("t4_busy_after", busy, 0);

    // Consumer takes the old byte in the exact cycle the next one completes.
    resetDut();
    hsBase = handshakeQ.size();
    startFrame();
    applyStimulus(8'h5A, 8, 1'b0, misoByte);
    checkOutput("t5_first_valid", rx_valid, 1);
    applyStimulus(8'h96, 8, 1'b1, misoByte);
    h0 = (handshakeQ.size() > hsBase) ? handshakeQ[hsBase] : 8'h00;
    checkOutput("t5_rx_data", rx_data, 8'h96);
    checkOutput("t5_rx_valid", rx_valid, 1);
    checkOutput("t5_overrun", overrun, 0);
    checkOutput("t5_handshakes", handshakeQ.size() - hsBase, 1);
    checkOutput("t5_taken", h0, 8'h5A);
    endFrame();

    // Reset after three bits, then a clean frame.
    resetDut();
    tx_valid = 1'b0;
    startFrame();
    applyStimulus(8'hE0, 3, 1'b0, misoByte);
    checkOutput("t6_underrun_pre", underrun, 1);
    checkOutput("t6_busy_pre", busy, 1);
    base = frameErrCount;
    rst = 1'b1; CS = 1'b1;
    waitClocks(1);
    rst = 1'b0;
    waitClocks(4);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_miso", MISO, 0);
    checkOutput("t6_rx_valid", rx_valid, 0);
    checkOutput("t6_rx_data", rx_data, 8'h00);
    checkOutput("t6_underrun", underrun, 0);
    checkOutput("t6_overrun", overrun, 0);
    checkOutput("t6_tx_ready", tx_ready, 0);
    checkOutput("t6_frame_error", frameErrCount - base, 0);
    tx_data = 8'h81; tx_valid = 1'b1;
    startFrame();
    tx_valid = 1'b0;
    applyStimulus(8'hC3, 8, 1'b0, misoByte);
    checkOutput("t6_miso_byte", misoByte, 8'h81);
    checkOutput("t6_new_rx_data", rx_data, 8'hC3);
    checkOutput("t6_new_rx_valid", rx_valid, 1);
    endFrame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
